instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Fetch/decode stage between program memory and program_counter. Drives memory address
//  from the PC, registers each fetched word as opcode+operand, and issues exactly one
//  2-bit PC command per cycle. Provides the MC14500B JMP/RTN/FLAG pulses and squashes
//  wrong-path fetches after JMP/CALL/RTN and taken SKZ. Feeds the logic unit downstream.
// PARAMETERS
//  ADDR_WIDTH     8  program address width; matches program_counter ADDR_WIDTH
//  OPERAND_WIDTH  8  operand field width; must be >= ADDR_WIDTH
//  INSTR_WIDTH    4+OPERAND_WIDTH  memory word: [INSTR_WIDTH-1 -: 4] opcode, [OPERAND_WIDTH-1:0] operand
// PORTS
//  clk            in   1              single clock, all state on posedge
//  reset          in   1              asynchronous, active-high; also wired to program_counter reset
//  pc_address     in   ADDR_WIDTH     program_counter address_out
//  mem_addr       out  ADDR_WIDTH     program memory read address (= pc_address, combinational)
//  mem_data       in   INSTR_WIDTH    synchronous ROM data, 1-cycle read latency
//  rr             in   1              logic-unit result register, sampled for SKZ
//  pc_instruction out  2              00 INC, 01 JMP, 10 RTN, 11 CALL
//  pc_address_in  out  ADDR_WIDTH     jump/call target = operand[ADDR_WIDTH-1:0]
//  exec_valid     out  1              opcode/operand are a live instruction this cycle
//  opcode         out  4              current decode opcode
//  operand        out  OPERAND_WIDTH  current decode operand
//  jmp_flag       out  1              1-cycle pulse, live JMP (1100)
//  rtn_flag       out  1              1-cycle pulse, live RTN (1101)
//  flag_o         out  1              1-cycle pulse, live NOPO (0000)
//  flag_f         out  1              1-cycle pulse, live NOPF (1111)
// BEHAVIOUR
//  - Decode slot = mem_data of current cycle (word addressed in previous cycle); not re-registered.
//  - States: FILL, RUN, SQUASH. Async reset -> FILL; all flags, exec_valid = 0; pc_instruction = INC.
//  - FILL: one cycle after reset release; mem_data invalid; exec_valid=0; issue INC; -> RUN.
//  - RUN: exec_valid=1; decode opcode:
//      1100 JMP  -> pc_instruction=01, jmp_flag=1, -> SQUASH
//      1101 RTN  -> pc_instruction=10, rtn_flag=1, -> SQUASH (resume at return addr, no skip)
//      1111 NOPF -> pc_instruction=11 (CALL), flag_f=1, -> SQUASH
//      1110 SKZ  -> INC; if rr==0 -> SQUASH else stay RUN
//      0000 NOPO -> INC, flag_o=1; all other opcodes -> INC, stay RUN
//  - SQUASH: slot holds wrong-path word; exec_valid=0, all flags 0, pc_instruction=INC
//    regardless of its opcode (a squashed JMP/SKZ is ignored); -> RUN.
//  - Control outputs are combinational from state+mem_data; pc_address_in always = operand
//    slice (don't-care unless JMP/CALL). Taken-branch penalty: exactly 1 squashed slot.
//  - Return address: CALL at A leaves A+1 in caller stack entry; RTN resumes at A+1.
//  - Stack depth/overflow is program_counter's concern; sequencer does not track depth.
//  - Reset mid-operation: immediately drop to FILL, outputs to reset values; reset must span
//    >=1 posedge so program_counter's synchronous reset takes effect (PC=0 on release).
//  - Back-to-back: SKZ(rr=0) then JMP -> JMP squashed; JMP then SKZ -> SKZ squashed, rr ignored.
// TESTING
//  1 reset, ROM 0:LD 1:AND 2:STO -> FILL cycle exec_valid=0; then opcodes 1,3,8 with exec_valid=1, PC 1,2,3
//  2 ROM 3:JMP 0x10, 4:LD, 0x10:OR -> jmp_flag pulse, 01 with target 0x10, word 4 squashed, next live OR
//  3 CALL(NOPF 0x20) at 5, 0x20:RTN, 6:LD -> flag_f, 11/0x20; rtn_flag, 10; squashes; LD at 6 executes
//  4 SKZ at 7 with rr=0 -> word 8 squashed (even if JMP); repeat rr=1 -> word 8 executes
//  5 0:NOPO -> flag_o=1 one cycle, INC; async reset asserted mid-JMP -> outputs 0 same cycle, restart at 0
//  6 JMP followed by SKZ in squash slot, rr=0 -> no extra skip; target word executes next

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode stage between program memory and program_counter.
//
// Drives the memory read address straight from the PC, treats the synchronous ROM output as
// the decode slot, and issues one 2-bit PC command every cycle. Produces the MC14500B
// JMP/RTN/FLAG pulses and squashes the single wrong-path fetch that follows a JMP, CALL,
// RTN or a taken SKZ.
//
// Ports:
//   clk            - clock, all state on posedge
//   reset          - asynchronous active-high reset (also resets program_counter)
//   pc_address     - current PC from program_counter
//   mem_addr       - program memory read address (= pc_address)
//   mem_data       - ROM word addressed in the previous cycle (opcode + operand)
//   rr             - logic-unit result register, tested by SKZ
//   pc_instruction - PC command: 00 INC, 01 JMP, 10 RTN, 11 CALL
//   pc_address_in  - jump/call target (operand slice)
//   exec_valid     - opcode/operand hold a live instruction this cycle
//   opcode/operand - current decode slot fields
//   jmp_flag, rtn_flag, flag_o, flag_f - one-cycle pulses for live JMP/RTN/NOPO/NOPF

module instruction_sequencer #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned OPERAND_WIDTH = 8,
    parameter int unsigned INSTR_WIDTH   = 4 + OPERAND_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    pc_address,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [INSTR_WIDTH-1:0]   mem_data,
    input  logic                     rr,
    output logic [1:0]               pc_instruction,
    output logic [ADDR_WIDTH-1:0]    pc_address_in,
    output logic                     exec_valid,
    output logic [3:0]               opcode,
    output logic [OPERAND_WIDTH-1:0] operand,
    output logic                     jmp_flag,
    output logic                     rtn_flag,
    output logic                     flag_o,
    output logic                     flag_f
);

    localparam logic [1:0] PcInc  = 2'b00;
    localparam logic [1:0] PcJmp  = 2'b01;
    localparam logic [1:0] PcRtn  = 2'b10;
    localparam logic [1:0] PcCall = 2'b11;

    localparam logic [3:0] OpNopo = 4'b0000;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpRtn  = 4'b1101;
    localparam logic [3:0] OpSkz  = 4'b1110;
    localparam logic [3:0] OpNopf = 4'b1111;

    typedef enum logic [1:0] {
        StFill   = 2'b00,
        StRun    = 2'b01,
        StSquash = 2'b10
    } state_e;

    state_e state_q, state_d;

    // The ROM already registers the word, so the decode slot is used as-is.
    assign mem_addr      = pc_address;
    assign opcode        = mem_data[INSTR_WIDTH-1 -: 4];
    assign operand       = mem_data[OPERAND_WIDTH-1:0];
    assign pc_address_in = operand[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_instruction = PcInc;
        exec_valid     = 1'b0;
        jmp_flag       = 1'b0;
        rtn_flag       = 1'b0;
        flag_o         = 1'b0;
        flag_f         = 1'b0;

        unique case (state_q)
            // First cycle after reset: ROM output does not yet reflect PC 0.
            StFill: begin
                state_d = StRun;
            end
            StRun: begin
                exec_valid = 1'b1;
                case (opcode)
                    OpJmp: begin
                        pc_instruction = PcJmp;
                        jmp_flag       = 1'b1;
                        state_d        = StSquash;
                    end
                    OpRtn: begin
                        pc_instruction = PcRtn;
                        rtn_flag       = 1'b1;
                        state_d        = StSquash;
                    end
                    // NOPF doubles as CALL to the operand address.
                    OpNopf: begin
                        pc_instruction = PcCall;
                        flag_f         = 1'b1;
                        state_d        = StSquash;
                    end
                    OpSkz: begin
                        if (!rr) begin
                            state_d = StSquash;
                        end
                    end
                    OpNopo: begin
                        flag_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            // Wrong-path word: ignored whatever its opcode.
            StSquash: begin
                state_d = StRun;
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc_address;
    logic [7:0]  mem_addr;
    logic [11:0] mem_data;
    logic        rr;
    logic [1:0]  pc_instruction;
    logic [7:0]  pc_address_in;
    logic        exec_valid;
    logic [3:0]  opcode;
    logic [7:0]  operand;
    logic        jmp_flag;
    logic        rtn_flag;
    logic        flag_o;
    logic        flag_f;

    int tests_run = 0;
    int tests_failed = 0;

    instruction_sequencer #(
        .ADDR_WIDTH   (8),
        .OPERAND_WIDTH(8),
        .INSTR_WIDTH  (12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_address    (pc_address),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .rr            (rr),
        .pc_instruction(pc_instruction),
        .pc_address_in (pc_address_in),
        .exec_valid    (exec_valid),
        .opcode        (opcode),
        .operand       (operand),
        .jmp_flag      (jmp_flag),
        .rtn_flag      (rtn_flag),
        .flag_o        (flag_o),
        .flag_f        (flag_f)
    );

    always #5 clk = ~clk;

    // flags = {jmp_flag, rtn_flag, flag_o, flag_f}
    typedef struct {
        logic [11:0] word;
        logic        rr;
        logic [7:0]  pc;
        logic        valid;
        logic [1:0]  pcin;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [11:0] word, logic r, logic [7:0] pc, logic valid,
                                logic [1:0] pcin, logic [3:0] flags);
        vec_t v;
        v.word  = word;
        v.rr    = r;
        v.pc    = pc;
        v.valid = valid;
        v.pcin  = pcin;
        v.flags = flags;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic valid, input logic [1:0] pcin,
                                 input logic [3:0] flags);
        check("exec_valid", idx, 32'(exec_valid), 32'(valid));
        check("pc_instruction", idx, 32'(pc_instruction), 32'(pcin));
        check("flags", idx, 32'({jmp_flag, rtn_flag, flag_o, flag_f}), 32'(flags));
    endtask

    // Drive one slot, check combinational outputs mid-cycle, then advance one clock.
    task automatic apply(input int idx, input vec_t v);
        mem_data   = v.word;
        rr         = v.rr;
        pc_address = v.pc;
        #2;
        check_outputs(idx, v.valid, v.pcin, v.flags);
        check("mem_addr", idx, 32'(mem_addr), 32'(v.pc));
        check("pc_address_in", idx, 32'(pc_address_in), 32'(v.word[7:0]));
        if (v.valid) begin
            check("opcode", idx, 32'(opcode), 32'(v.word[11:8]));
            check("operand", idx, 32'(operand), 32'(v.word[7:0]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Slots in order from reset release. pc is what the PC would hold that cycle.
        vecs.push_back(mk(12'hC_FF, 1'b0, 8'h00, 1'b0, 2'b00, 4'b0000)); // FILL, garbage ignored
        vecs.push_back(mk(12'h1_00, 1'b0, 8'h01, 1'b1, 2'b00, 4'b0000)); // 0: LD
        vecs.push_back(mk(12'h3_00, 1'b0, 8'h02, 1'b1, 2'b00, 4'b0000)); // 1: AND
        vecs.push_back(mk(12'h8_00, 1'b0, 8'h03, 1'b1, 2'b00, 4'b0000)); // 2: STO
        vecs.push_back(mk(12'hC_10, 1'b0, 8'h04, 1'b1, 2'b01, 4'b1000)); // 3: JMP 0x10
        vecs.push_back(mk(12'h1_00, 1'b0, 8'h10, 1'b0, 2'b00, 4'b0000)); // 4: LD squashed
        vecs.push_back(mk(12'h5_00, 1'b0, 8'h11, 1'b1, 2'b00, 4'b0000)); // 0x10: OR
        vecs.push_back(mk(12'hF_20, 1'b0, 8'h06, 1'b1, 2'b11, 4'b0001)); // 5: NOPF/CALL 0x20
        vecs.push_back(mk(12'h1_00, 1'b0, 8'h20, 1'b0, 2'b00, 4'b0000)); // 6: squashed
        vecs.push_back(mk(12'hD_00, 1'b0, 8'h21, 1'b1, 2'b10, 4'b0100)); // 0x20: RTN
        vecs.push_back(mk(12'h2_00, 1'b0, 8'h06, 1'b0, 2'b00, 4'b0000)); // 0x21: squashed
        vecs.push_back(mk(12'h1_00, 1'b0, 8'h07, 1'b1, 2'b00, 4'b0000)); // 6: LD executes
        vecs.push_back(mk(12'hE_00, 1'b0, 8'h08, 1'b1, 2'b00, 4'b0000)); // 7: SKZ rr=0 taken
        vecs.push_back(mk(12'hC_30, 1'b0, 8'h09, 1'b0, 2'b00, 4'b0000)); // 8: JMP squashed
        vecs.push_back(mk(12'hE_00, 1'b1, 8'h08, 1'b1, 2'b00, 4'b0000)); // 7: SKZ rr=1
        vecs.push_back(mk(12'hC_30, 1'b1, 8'h09, 1'b1, 2'b01, 4'b1000)); // 8: JMP executes
        vecs.push_back(mk(12'hE_00, 1'b0, 8'h30, 1'b0, 2'b00, 4'b0000)); // SKZ in squash slot
        vecs.push_back(mk(12'h1_00, 1'b0, 8'h31, 1'b1, 2'b00, 4'b0000)); // 0x30: target runs
        vecs.push_back(mk(12'h0_00, 1'b0, 8'h32, 1'b1, 2'b00, 4'b0010)); // NOPO
        vecs.push_back(mk(12'hE_00, 1'b0, 8'h33, 1'b1, 2'b00, 4'b0000)); // SKZ rr=0
        vecs.push_back(mk(12'h0_00, 1'b0, 8'h34, 1'b0, 2'b00, 4'b0000)); // NOPO squashed
        vecs.push_back(mk(12'hF_40, 1'b0, 8'h35, 1'b1, 2'b11, 4'b0001)); // NOPF/CALL 0x40
        vecs.push_back(mk(12'hD_00, 1'b0, 8'h40, 1'b0, 2'b00, 4'b0000)); // RTN squashed
        vecs.push_back(mk(12'h7_AB, 1'b0, 8'h41, 1'b1, 2'b00, 4'b0000)); // XNOR, operand 0xAB

        // Reset state, asserted from time 0 with a JMP word on the bus.
        reset      = 1'b1;
        mem_data   = 12'hC_55;
        rr         = 1'b0;
        pc_address = 8'h00;
        #1;
        check_outputs(-1, 1'b0, 2'b00, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs(-2, 1'b0, 2'b00, 4'b0000);
        reset = 1'b0;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Async reset in the middle of a live JMP: outputs drop without a clock edge.
        mem_data   = 12'hC_77;
        pc_address = 8'h42;
        #2;
        check_outputs(100, 1'b1, 2'b01, 4'b1000);
        reset = 1'b1;
        #1;
        check_outputs(101, 1'b0, 2'b00, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Restart: FILL then word 0 (NOPO) executes.
        apply(102, mk(12'h0_00, 1'b0, 8'h00, 1'b0, 2'b00, 4'b0000));
        apply(103, mk(12'h0_00, 1'b0, 8'h01, 1'b1, 2'b00, 4'b0010));
        apply(104, mk(12'h1_00, 1'b0, 8'h02, 1'b1, 2'b00, 4'b0000));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
